// File: rtl/stdp_if.sv
// ----------------------------------------------------------------------------
// stdp_if
// Bundles the signals between the STDP update engine and its surroundings:
// the post-spike trigger, the status flags, and the read/write ports of the
// weight RAM plus the pre-synaptic spike RAM.
//   master : the update engine (drives addresses, write data, status)
//   slave  : RAM / controller side (drives start, read data, pre flag)
// Signals:
//   start   one-cycle post-spike trigger
//   addr_r  read address to weight RAM and pre-spike RAM
//   data_r  registered weight read data (1-cycle latency)
//   pre_hit registered pre-synaptic spike flag (1-cycle latency)
//   addr_w  weight RAM write address
//   data_w  saturated updated weight
//   we      weight RAM write enable
//   busy    sweep in progress
//   done    one-cycle end-of-sweep pulse
// ----------------------------------------------------------------------------
interface stdp_if #(
    parameter int AW = 10,
    parameter int W  = 24
);
    logic                 start;
    logic [AW-1:0]        addr_r;
    logic signed [W-1:0]  data_r;
    logic                 pre_hit;
    logic [AW-1:0]        addr_w;
    logic signed [W-1:0]  data_w;
    logic                 we;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, data_r, pre_hit,
        output addr_r, addr_w, data_w, we, busy, done
    );

    modport slave (
        output start, data_r, pre_hit,
        input  addr_r, addr_w, data_w, we, busy, done
    );
endinterface

// File: rtl/stdp_weight_update.sv
// ----------------------------------------------------------------------------
// stdp_weight_update
// Read-modify-write STDP learning engine in front of the weight RAM. A start
// pulse sweeps all M synapse addresses, one per clock. Each weight is read
// together with its pre-synaptic spike flag, potentiated (flag=1) or
// depressed (flag=0), clamped to [WMIN,WMAX] and written back two cycles
// after its read address was issued, giving one write per cycle.
// Ports:
//   clk  single clock, everything on posedge
//   rst  synchronous active-high reset
//   bus  stdp_if master modport (start/busy/done and RAM read/write ports)
// ----------------------------------------------------------------------------
module stdp_weight_update #(
    parameter int M      = 784,
    parameter int W      = 24,
    parameter int AW     = 10,
    parameter int WMAX   = 65536,
    parameter int WMIN   = -65536,
    parameter int DW_POT = 256,
    parameter int DW_DEP = 128
) (
    input  logic     clk,
    input  logic     rst,
    stdp_if.master   bus
);

    localparam int SW = W + 2;
    localparam logic [AW-1:0]        LAST   = AW'(M - 1);
    localparam logic signed [SW-1:0] MAX_X  = SW'(WMAX);
    localparam logic signed [SW-1:0] MIN_X  = SW'(WMIN);
    localparam logic signed [SW-1:0] POT_X  = SW'(DW_POT);
    localparam logic signed [SW-1:0] DEP_X  = SW'(DW_DEP);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [AW-1:0]       addr_r_q;
    logic [AW-1:0]       rd_addr;   // address whose data is on data_r this cycle
    logic                rd_vld;    // data_r/pre_hit belong to a swept address
    logic [AW-1:0]       addr_w_q;
    logic signed [W-1:0] data_w_q;
    logic                we_q;

    logic signed [SW-1:0] data_ext;
    logic signed [SW-1:0] sum;
    logic signed [W-1:0]  sat;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_nx is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.start)         state_nx = READ;
            READ:  if (addr_r_q == LAST)  state_nx = DRAIN;
            // rd_vld low means the final read has already moved into the
            // write stage, so the last write is on the bus this cycle.
            DRAIN: if (!rd_vld)           state_nx = DONE;
            DONE:                         state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Update arithmetic: two guard bits make the add/sub overflow-free,
    // so the clamp compares against the true sum.
    // ------------------------------------------------------------------
    always_comb begin
        data_ext = {{2{bus.data_r[W-1]}}, bus.data_r};
        sum      = bus.pre_hit ? (data_ext + POT_X) : (data_ext - DEP_X);
        if (sum > MAX_X)      sat = MAX_X[W-1:0];
        else if (sum < MIN_X) sat = MIN_X[W-1:0];
        else                  sat = sum[W-1:0];
    end

    // ------------------------------------------------------------------
    // Address generator and two-stage read/write pipeline
    // ------------------------------------------------------------------
    // NOTE: the pipeline registers are reset so a mid-sweep reset drops
    // the in-flight write immediately; the RAM itself is never cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r_q <= '0;
            rd_addr  <= '0;
            rd_vld   <= 1'b0;
            addr_w_q <= '0;
            data_w_q <= '0;
            we_q     <= 1'b0;
        end else begin
            if (state == IDLE && bus.start)
                addr_r_q <= '0;
            else if (state == READ && addr_r_q != LAST)
                addr_r_q <= addr_r_q + 1'b1;

            // Read stage: RAM samples addr_r at this edge.
            rd_vld  <= (state == READ);
            rd_addr <= addr_r_q;

            // Write stage: read data is valid in the cycle after the read.
            we_q <= rd_vld;
            if (rd_vld) begin
                addr_w_q <= rd_addr;
                data_w_q <= sat;
            end
        end
    end

    assign bus.addr_r = addr_r_q;
    assign bus.addr_w = addr_w_q;
    assign bus.data_w = data_w_q;
    assign bus.we     = we_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_stdp_weight_update.sv
// ----------------------------------------------------------------------------
// tb_stdp_weight_update
// Directed bench for stdp_weight_update. A behavioural weight RAM and
// pre-spike RAM (1-cycle registered reads) sit on the slave side of the
// interface. Each scenario task drives stimulus and compares against
// hand-computed constants.
// ----------------------------------------------------------------------------
module tb_stdp_weight_update;

    localparam int M  = 784;
    localparam int W  = 24;
    localparam int AW = 10;

    logic clk;
    logic rst;

    stdp_if #(.AW(AW), .W(W)) bus ();

    stdp_weight_update #(
        .M(M), .W(W), .AW(AW),
        .WMAX(65536), .WMIN(-65536), .DW_POT(256), .DW_DEP(128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------
    // RAM models
    // ------------------------------------------------------------------
    logic signed [W-1:0] mem [M];
    logic                pre_mem [M];
    logic                tb_fill, tb_wr;
    logic [AW-1:0]       tb_addr;
    logic signed [W-1:0] tb_data;

    always @(posedge clk) begin
        bus.data_r  <= mem[bus.addr_r];
        bus.pre_hit <= pre_mem[bus.addr_r];
        if (tb_fill)
            for (int i = 0; i < M; i++) mem[i] <= tb_data;
        else if (tb_wr)
            mem[tb_addr] <= tb_data;
        else if (bus.we)
            mem[bus.addr_w] <= bus.data_w;
    end

    task automatic fill_mem(input int v);
        tb_data = v[W-1:0]; tb_fill = 1'b1;
        @(posedge clk); #1;
        tb_fill = 1'b0;
    endtask

    task automatic set_mem(input int a, input int v);
        tb_addr = a[AW-1:0]; tb_data = v[W-1:0]; tb_wr = 1'b1;
        @(posedge clk); #1;
        tb_wr = 1'b0;
    endtask

    // mode 0: all zero, 1: all one, 2: one on even addresses
    task automatic set_pre(input int mode);
        for (int i = 0; i < M; i++)
            pre_mem[i] = (mode == 1) || (mode == 2 && (i % 2 == 0));
    endtask

    // Counts addresses not matching the four-value pattern: below `split`
    // even/odd expect e_lo/o_lo, from `split` on expect e_hi/o_hi.
    int first_bad;
    function automatic int mem_errs(input int e_lo, input int o_lo,
                                    input int e_hi, input int o_hi,
                                    input int split);
        int n = 0;
        int e;
        first_bad = -1;
        for (int i = 0; i < M; i++) begin
            if (i < split) e = (i % 2 == 0) ? e_lo : o_lo;
            else           e = (i % 2 == 0) ? e_hi : o_hi;
            if (mem[i] !== e) begin
                n++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Sweep driver: called #1 after an edge with the DUT idle. Cycle 1 is
    // the acceptance edge; returns after the edge following done.
    // ------------------------------------------------------------------
    int accepted, cycles, writes, dones, first_we, last_we, probe_val;
    int busy_gap, we_idle, post_busy, post_done;

    task automatic run_sweep(input int probe, input int restart_at);
        int cyc;
        int done_cyc;
        writes = 0; dones = 0; first_we = 0; last_we = 0; probe_val = 0;
        busy_gap = 0; we_idle = 0; done_cyc = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        accepted = bus.busy;
        for (int i = 0; i < 2000 && done_cyc == 0; i++) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = (cyc == restart_at);
            if (bus.we) begin
                writes++;
                if (first_we == 0) first_we = cyc;
                last_we = cyc;
                if (int'(bus.addr_w) == probe) probe_val = bus.data_w;
            end
            if (!bus.busy) busy_gap = 1;
            if (bus.we && !bus.busy) we_idle = 1;
            if (bus.done) begin
                dones++;
                done_cyc = cyc;
            end
        end
        cycles = done_cyc;
        bus.start = 1'b0;
        @(posedge clk); #1;
        post_busy = bus.busy;
        post_done = bus.done;
        if (bus.we) writes++;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        // start asserted together with rst: rst must win
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++; if (bus.addr_r !== '0) begin bad++; $display("FAIL reset_addr_r: got %0d want 0", bus.addr_r); end
        total++; if (bus.addr_w !== '0) begin bad++; $display("FAIL reset_addr_w: got %0d want 0", bus.addr_w); end
        total++; if (bus.data_w !== '0) begin bad++; $display("FAIL reset_data_w: got %0d want 0", bus.data_w); end
        total++; if (bus.we !== 1'b0)   begin bad++; $display("FAIL reset_we: got %b want 0", bus.we); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_after: busy got %b want 0", bus.busy); end
    endtask

    task automatic test_nominal();
        int n;
        fill_mem(0);
        set_pre(2);
        run_sweep(0, 0);
        total++; if (accepted != 1)  begin bad++; $display("FAIL nom_accept: busy got %0d want 1", accepted); end
        total++; if (probe_val != 256) begin bad++; $display("FAIL nom_first_data: got %0d want 256", probe_val); end
        total++; if (first_we != 3)  begin bad++; $display("FAIL nom_first_we: cycle got %0d want 3", first_we); end
        total++; if (last_we != 786) begin bad++; $display("FAIL nom_last_we: cycle got %0d want 786", last_we); end
        total++; if (cycles != 787)  begin bad++; $display("FAIL nom_done_latency: got %0d want 787", cycles); end
        total++; if (writes != 784)  begin bad++; $display("FAIL nom_writes: got %0d want 784", writes); end
        total++; if (dones != 1 || post_done != 0) begin bad++; $display("FAIL nom_done_pulse: dones %0d post %0d want 1/0", dones, post_done); end
        total++; if (post_busy != 0) begin bad++; $display("FAIL nom_busy_end: got %0d want 0", post_busy); end
        total++; if (we_idle != 0)   begin bad++; $display("FAIL nom_we_idle: got %0d want 0", we_idle); end
        n = mem_errs(256, -128, 256, -128, M);
        total++; if (n != 0) begin bad++; $display("FAIL nom_mem: %0d bad words, first at %0d got %0d", n, first_bad, mem[first_bad]); end
    endtask

    task automatic test_ceiling();
        fill_mem(0);
        set_mem(5, 65500);
        set_mem(6, 65280);
        set_mem(7, 65281);
        set_pre(1);
        run_sweep(5, 0);
        total++; if (probe_val != 65536) begin bad++; $display("FAIL ceil_data_w: got %0d want 65536", probe_val); end
        total++; if (mem[5] !== 65536) begin bad++; $display("FAIL ceil_mem5: got %0d want 65536", mem[5]); end
        total++; if (mem[6] !== 65536) begin bad++; $display("FAIL ceil_exact: got %0d want 65536", mem[6]); end
        total++; if (mem[7] !== 65536) begin bad++; $display("FAIL ceil_over1: got %0d want 65536", mem[7]); end
        run_sweep(5, 0);
        total++; if (probe_val != 65536) begin bad++; $display("FAIL ceil2_data_w: got %0d want 65536", probe_val); end
        total++; if (mem[5] !== 65536) begin bad++; $display("FAIL ceil2_mem5: got %0d want 65536", mem[5]); end
        total++; if (mem[4] !== 512)   begin bad++; $display("FAIL ceil2_mem4: got %0d want 512", mem[4]); end
    endtask

    task automatic test_floor();
        fill_mem(0);
        set_mem(783, -65500);
        set_mem(782, -65408);
        set_pre(0);
        run_sweep(783, 0);
        total++; if (probe_val != -65536) begin bad++; $display("FAIL floor_data_w: got %0d want -65536", probe_val); end
        total++; if (mem[783] !== -65536) begin bad++; $display("FAIL floor_mem783: got %0d want -65536", mem[783]); end
        total++; if (mem[782] !== -65536) begin bad++; $display("FAIL floor_exact: got %0d want -65536", mem[782]); end
        total++; if (mem[0] !== -128)     begin bad++; $display("FAIL floor_mem0: got %0d want -128", mem[0]); end
        total++; if (bus.addr_r !== 10'd783) begin bad++; $display("FAIL floor_addr_hold: got %0d want 783", bus.addr_r); end
    endtask

    task automatic test_ignored_start();
        int n;
        fill_mem(0);
        set_pre(2);
        run_sweep(-1, 100);
        total++; if (writes != 784) begin bad++; $display("FAIL ign_writes: got %0d want 784", writes); end
        total++; if (dones != 1 || post_done != 0) begin bad++; $display("FAIL ign_done: dones %0d post %0d want 1/0", dones, post_done); end
        total++; if (busy_gap != 0) begin bad++; $display("FAIL ign_busy: gap got %0d want 0", busy_gap); end
        total++; if (cycles != 787) begin bad++; $display("FAIL ign_latency: got %0d want 787", cycles); end
        n = mem_errs(256, -128, 256, -128, M);
        total++; if (n != 0) begin bad++; $display("FAIL ign_mem: %0d bad words, first at %0d", n, first_bad); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        int seen = 0;
        fill_mem(1000);
        set_pre(2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2000 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (bus.we && bus.addr_w == 10'd299) seen = 1;
        end
        total++; if (seen != 1) begin bad++; $display("FAIL rstmid_reach299: got %0d want 1", seen); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (bus.we !== 1'b0)   begin bad++; $display("FAIL rstmid_we: got %b want 0", bus.we); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        @(posedge clk); #1;
        n = mem_errs(1256, 872, 1000, 1000, 300);
        total++; if (n != 0) begin bad++; $display("FAIL rstmid_mem: %0d bad words, first at %0d got %0d", n, first_bad, mem[first_bad]); end
        run_sweep(-1, 0);
        total++; if (writes != 784 || dones != 1) begin bad++; $display("FAIL rstmid_resweep: writes %0d dones %0d want 784/1", writes, dones); end
        n = mem_errs(1512, 744, 1256, 872, 300);
        total++; if (n != 0) begin bad++; $display("FAIL rstmid_mem2: %0d bad words, first at %0d got %0d", n, first_bad, mem[first_bad]); end
    endtask

    task automatic test_back_to_back();
        int n;
        fill_mem(0);
        set_pre(2);
        run_sweep(-1, 0);
        // run_sweep returns in the cycle after done; start is raised now
        run_sweep(-1, 0);
        total++; if (accepted != 1) begin bad++; $display("FAIL b2b_accept: busy got %0d want 1", accepted); end
        total++; if (writes != 784 || cycles != 787) begin bad++; $display("FAIL b2b_sweep: writes %0d cycles %0d want 784/787", writes, cycles); end
        n = mem_errs(512, -256, 512, -256, M);
        total++; if (n != 0) begin bad++; $display("FAIL b2b_mem: %0d bad words, first at %0d got %0d", n, first_bad, mem[first_bad]); end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        tb_fill = 1'b0;
        tb_wr   = 1'b0;
        tb_addr = '0;
        tb_data = '0;
        set_pre(0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_nominal();
        test_ceiling();
        test_floor();
        test_ignored_start();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
